// File: rtl/exu_mem_lsu.sv
// Load/store unit: one req/gnt/rvalid bus transaction per memory op, byte-lane alignment and load extension.
// Store busy for acceptance + REQ cycles, load until writeback; stall_o holds upstream for the whole transaction.
module exu_mem_lsu #(
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_mem_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [2:0]  mem_op_i,
    input  logic        mem_store_i,
    input  logic [4:0]  rd_waddr_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_sel_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        reg_we_o,
    output logic [4:0]  reg_waddr_o,
    output logic [31:0] reg_wdata_o,
    output logic        stall_o,
    output logic        misaligned_o,
    output logic        mem_err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    // The counter reads 0 in the first cycle of a state, so the last allowed cycle holds BUS_TIMEOUT-1.
    localparam logic [15:0] CNT_LAST = 16'(BUS_TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  sel_q;
    logic [2:0]  op_q;
    logic        store_q;
    logic [4:0]  rd_q;
    logic [15:0] cnt;

    logic        misaligned;
    logic        accept;
    logic        abort;
    logic        load_done;
    logic        cnt_last;
    logic [3:0]  sel_in;
    logic [31:0] wdata_in;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    always_comb begin
        misaligned = 1'b0;
        case (mem_op_i[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = mem_addr_i[0];
            default: misaligned = |mem_addr_i[1:0];
        endcase
    end

    assign accept   = (state == IDLE) && req_mem_i && !misaligned;
    assign cnt_last = (cnt == CNT_LAST);

    always_comb begin
        sel_in   = 4'b1111;
        wdata_in = mem_wdata_i;
        case (mem_op_i[1:0])
            2'b00: begin
                if (mem_store_i) sel_in = 4'b0001 << mem_addr_i[1:0];
                wdata_in = {4{mem_wdata_i[7:0]}};
            end
            2'b01: begin
                if (mem_store_i) sel_in = mem_addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_in = {2{mem_wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        abort     = 1'b0;
        load_done = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = REQ;
            end
            REQ: begin
                // A handshake in the final allowed cycle beats the timeout.
                if (mem_gnt_i) begin
                    state_nxt = store_q ? IDLE : WAIT;
                end else if (cnt_last) begin
                    state_nxt = IDLE;
                    abort     = 1'b1;
                end
            end
            WAIT: begin
                if (mem_rvalid_i) begin
                    state_nxt = IDLE;
                    load_done = 1'b1;
                end else if (cnt_last) begin
                    state_nxt = IDLE;
                    abort     = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ld_byte = mem_rdata_i[7:0];
        case (addr_q[1:0])
            2'd0: ld_byte = mem_rdata_i[7:0];
            2'd1: ld_byte = mem_rdata_i[15:8];
            2'd2: ld_byte = mem_rdata_i[23:16];
            2'd3: ld_byte = mem_rdata_i[31:24];
            default: ;
        endcase
        ld_half = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        ld_data = mem_rdata_i;
        case (op_q)
            3'b000: ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001: ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100: ld_data = {24'd0, ld_byte};
            3'b101: ld_data = {16'd0, ld_half};
            default: ld_data = mem_rdata_i;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            sel_q   <= 4'd0;
            op_q    <= 3'd0;
            store_q <= 1'b0;
            rd_q    <= 5'd0;
        end else if (accept) begin
            addr_q  <= mem_addr_i;
            wdata_q <= wdata_in;
            sel_q   <= sel_in;
            op_q    <= mem_op_i;
            store_q <= mem_store_i;
            rd_q    <= rd_waddr_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 16'd0;
        end else if (state_nxt != state) begin
            cnt <= 16'd0;
        end else if (state != IDLE) begin
            cnt <= cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misaligned_o <= 1'b0;
            mem_err_o    <= 1'b0;
            reg_we_o     <= 1'b0;
            reg_waddr_o  <= 5'd0;
            reg_wdata_o  <= 32'd0;
        end else begin
            misaligned_o <= (state == IDLE) && req_mem_i && misaligned;
            mem_err_o    <= abort;
            reg_we_o     <= load_done;
            if (load_done) begin
                reg_waddr_o <= rd_q;
                reg_wdata_o <= ld_data;
            end
        end
    end

    assign mem_req_o   = (state == REQ);
    assign mem_addr_o  = {addr_q[31:2], 2'b00};
    assign mem_we_o    = store_q;
    assign mem_sel_o   = sel_q;
    assign mem_wdata_o = wdata_q;
    assign stall_o     = (state != IDLE) || accept;

endmodule

// File: tb/tb_exu_mem_lsu.sv
// Self-checking bench for exu_mem_lsu: directed scenarios plus randomized transactions against a behavioural model.
module tb_exu_mem_lsu;

    localparam int TMO = 4;
    localparam int WIN = 14;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_mem_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [2:0]  mem_op_i;
    logic        mem_store_i;
    logic [4:0]  rd_waddr_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_sel_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        reg_we_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o;
    logic        stall_o;
    logic        misaligned_o;
    logic        mem_err_o;

    exu_mem_lsu #(.BUS_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .req_mem_i(req_mem_i), .mem_addr_i(mem_addr_i),
        .mem_wdata_i(mem_wdata_i), .mem_op_i(mem_op_i), .mem_store_i(mem_store_i),
        .rd_waddr_i(rd_waddr_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_we_o(mem_we_o), .mem_sel_o(mem_sel_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o),
        .stall_o(stall_o), .misaligned_o(misaligned_o), .mem_err_o(mem_err_o)
    );

    initial forever #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    int          obs_stall, obs_req, obs_we, obs_we_k, obs_err, obs_err_k, obs_mis, obs_mis_k;
    logic [31:0] obs_addr, obs_wdata, obs_we_data;
    logic [3:0]  obs_sel;
    logic        obs_wen;
    logic [4:0]  obs_we_addr;
    bit          obs_unstable;

    typedef struct {
        bit          mis;
        int          n_stall;
        int          n_req;
        int          n_we;
        int          we_k;
        logic [31:0] we_data;
        int          n_err;
        logic [3:0]  sel;
        logic [31:0] wdata;
    } exp_t;

    // Expected outcome of one transaction; g = REQ cycles without grant, r = WAIT cycles before rvalid.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] op,
                                   input bit st, input int g, input int r, input logic [31:0] rdata);
        exp_t        e;
        int          size;
        int          off;
        logic [31:0] v;
        e.mis = 0; e.n_stall = 0; e.n_req = 0; e.n_we = 0; e.we_k = 0;
        e.we_data = 0; e.n_err = 0; e.sel = 0; e.wdata = 0;
        size  = int'(op) % 4;
        off   = int'(a % 4);
        e.mis = (size == 1 && off % 2 != 0) || (size >= 2 && off != 0);
        if (e.mis) return e;
        if (!st)            e.sel = 4'hF;
        else if (size == 0) e.sel = 4'(1 << off);
        else if (size == 1) e.sel = (off >= 2) ? 4'hC : 4'h3;
        else                e.sel = 4'hF;
        if (size == 0)      e.wdata = (wd % 256) * 32'h0101_0101;
        else if (size == 1) e.wdata = (wd % 65536) * 32'h0001_0001;
        else                e.wdata = wd;
        if (g >= TMO) begin
            e.n_req = TMO; e.n_stall = TMO + 1; e.n_err = 1;
            return e;
        end
        e.n_req = g + 1;
        if (st) begin
            e.n_stall = g + 2;
            return e;
        end
        if (r >= TMO) begin
            e.n_stall = g + 2 + TMO; e.n_err = 1;
            return e;
        end
        e.n_stall = g + r + 3;
        e.n_we    = 1;
        e.we_k    = g + r + 3;
        v = rdata >> (8 * off);
        if (size == 0) begin
            v = v % 256;
            if (!op[2] && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (size == 1) begin
            v = v % 65536;
            if (!op[2] && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = rdata;
        end
        e.we_data = v;
        return e;
    endfunction

    // Issues one instruction at k=0, acts as a bus slave, and records what the DUT did over WIN cycles.
    task automatic run_window(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] op, input bit st,
                              input logic [4:0] rd, input int g, input int r, input logic [31:0] rdata);
        int req_cnt;
        int kg;
        req_cnt = 0; kg = -1;
        obs_stall = 0; obs_req = 0; obs_we = 0; obs_we_k = -1; obs_err = 0; obs_err_k = -1;
        obs_mis = 0; obs_mis_k = -1; obs_unstable = 0;
        obs_addr = 0; obs_wdata = 0; obs_we_data = 0; obs_sel = 0; obs_wen = 0; obs_we_addr = 0;
        for (int k = 0; k < WIN; k++) begin
            @(negedge clk);
            req_mem_i = (k == 0);
            if (k == 0) begin
                mem_addr_i = a; mem_wdata_i = wd; mem_op_i = op; mem_store_i = st; rd_waddr_i = rd;
            end else begin
                mem_addr_i = $urandom; mem_wdata_i = $urandom; mem_op_i = 3'($urandom);
                mem_store_i = 1'($urandom); rd_waddr_i = 5'($urandom);
            end
            mem_gnt_i = mem_req_o && (req_cnt == g);
            if (mem_gnt_i) kg = k;
            if (mem_req_o) req_cnt++;
            mem_rvalid_i = !st && (kg >= 0) && (k == kg + 1 + r);
            mem_rdata_i  = mem_rvalid_i ? rdata : $urandom;
            #1;
            if (stall_o) obs_stall++;
            if (mem_req_o) begin
                obs_req++;
                if (obs_req == 1) begin
                    obs_addr = mem_addr_o; obs_sel = mem_sel_o; obs_wen = mem_we_o; obs_wdata = mem_wdata_o;
                end else if (mem_addr_o !== obs_addr || mem_sel_o !== obs_sel ||
                             mem_we_o !== obs_wen || mem_wdata_o !== obs_wdata) begin
                    obs_unstable = 1;
                end
            end
            if (reg_we_o) begin
                obs_we++; obs_we_k = k; obs_we_addr = reg_waddr_o; obs_we_data = reg_wdata_o;
            end
            if (mem_err_o) begin obs_err++; obs_err_k = k; end
            if (misaligned_o) begin obs_mis++; obs_mis_k = k; end
        end
        req_mem_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if ({mem_req_o, mem_we_o, stall_o, reg_we_o, misaligned_o, mem_err_o} !== 6'd0) begin
            n_miss++; $display("FAIL reset_ctrl got %b expected 000000",
                               {mem_req_o, mem_we_o, stall_o, reg_we_o, misaligned_o, mem_err_o});
        end
        n_vec++;
        if ({mem_addr_o, mem_sel_o, mem_wdata_o} !== 68'd0) begin
            n_miss++; $display("FAIL reset_bus got %h/%h/%h expected zeros", mem_addr_o, mem_sel_o, mem_wdata_o);
        end
        n_vec++;
        if ({reg_waddr_o, reg_wdata_o} !== 37'd0) begin
            n_miss++; $display("FAIL reset_wb got %h/%h expected zeros", reg_waddr_o, reg_wdata_o);
        end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_lw;
        run_window(32'h1000_0008, 32'h0, 3'b010, 0, 5'd5, 0, 1, 32'hDEAD_BEEF);
        n_vec++;
        if (obs_addr !== 32'h1000_0008 || obs_sel !== 4'hF || obs_wen !== 1'b0) begin
            n_miss++; $display("FAIL lw_bus got %h/%h/%b expected 10000008/f/0", obs_addr, obs_sel, obs_wen);
        end
        n_vec++;
        if (obs_we !== 1 || obs_we_data !== 32'hDEAD_BEEF || obs_we_addr !== 5'd5) begin
            n_miss++; $display("FAIL lw_wb got %0d/%h/%0d expected 1/deadbeef/5", obs_we, obs_we_data, obs_we_addr);
        end
        n_vec++;
        if (obs_stall !== 4 || obs_we_k !== 4) begin
            n_miss++; $display("FAIL lw_timing got stall %0d we_k %0d expected 4/4", obs_stall, obs_we_k);
        end
    endtask

    task automatic test_load_ext;
        run_window(32'h3000_0003, 32'h0, 3'b000, 0, 5'd9, 1, 0, 32'h80FF_1234);
        n_vec++;
        if (obs_we !== 1 || obs_we_data !== 32'hFFFF_FF80) begin
            n_miss++; $display("FAIL lb got %0d/%h expected 1/ffffff80", obs_we, obs_we_data);
        end
        run_window(32'h3000_0003, 32'h0, 3'b100, 0, 5'd9, 0, 2, 32'h80FF_1234);
        n_vec++;
        if (obs_we_data !== 32'h0000_0080) begin
            n_miss++; $display("FAIL lbu got %h expected 00000080", obs_we_data);
        end
        run_window(32'h3000_0002, 32'h0, 3'b001, 0, 5'd10, 0, 0, 32'h8001_0000);
        n_vec++;
        if (obs_we_data !== 32'hFFFF_8001 || obs_we_addr !== 5'd10) begin
            n_miss++; $display("FAIL lh got %h/%0d expected ffff8001/10", obs_we_data, obs_we_addr);
        end
    endtask

    task automatic test_store;
        run_window(32'h2000_0001, 32'h0000_00A5, 3'b000, 1, 5'd3, 3, 0, 32'h0);
        n_vec++;
        if (obs_sel !== 4'b0010 || obs_wdata !== 32'hA5A5_A5A5 || obs_addr !== 32'h2000_0000 || obs_wen !== 1'b1) begin
            n_miss++; $display("FAIL sb_bus got %b/%h/%h/%b expected 0010/a5a5a5a5/20000000/1",
                               obs_sel, obs_wdata, obs_addr, obs_wen);
        end
        n_vec++;
        if (obs_req !== 4 || obs_unstable !== 1'b0) begin
            n_miss++; $display("FAIL sb_hold got req %0d unstable %0d expected 4/0", obs_req, obs_unstable);
        end
        n_vec++;
        if (obs_we !== 0 || obs_err !== 0 || obs_stall !== 5) begin
            n_miss++; $display("FAIL sb_done got we %0d err %0d stall %0d expected 0/0/5", obs_we, obs_err, obs_stall);
        end
    endtask

    task automatic test_misaligned;
        run_window(32'h5000_0002, 32'h1234_5678, 3'b010, 1, 5'd0, 0, 0, 32'h0);
        n_vec++;
        if (obs_mis !== 1 || obs_mis_k !== 1 || obs_req !== 0 || obs_stall !== 0) begin
            n_miss++; $display("FAIL sw_misaligned got mis %0d@%0d req %0d stall %0d expected 1@1/0/0",
                               obs_mis, obs_mis_k, obs_req, obs_stall);
        end
        run_window(32'h5000_0001, 32'h0, 3'b001, 0, 5'd4, 0, 0, 32'h0);
        n_vec++;
        if (obs_mis !== 1 || obs_mis_k !== 1 || obs_req !== 0 || obs_stall !== 0 || obs_we !== 0) begin
            n_miss++; $display("FAIL lh_misaligned got mis %0d@%0d req %0d stall %0d we %0d expected 1@1/0/0/0",
                               obs_mis, obs_mis_k, obs_req, obs_stall, obs_we);
        end
    endtask

    task automatic test_timeout;
        run_window(32'h6000_0000, 32'h1, 3'b010, 1, 5'd0, 5, 0, 32'h0);
        n_vec++;
        if (obs_err !== 1 || obs_err_k !== 5 || obs_req !== 4 || obs_stall !== 5) begin
            n_miss++; $display("FAIL req_timeout got err %0d@%0d req %0d stall %0d expected 1@5/4/5",
                               obs_err, obs_err_k, obs_req, obs_stall);
        end
        run_window(32'h6000_0010, 32'h0, 3'b010, 0, 5'd6, 0, 5, 32'h5555_AAAA);
        n_vec++;
        if (obs_err !== 1 || obs_err_k !== 6 || obs_we !== 0) begin
            n_miss++; $display("FAIL wait_timeout got err %0d@%0d we %0d expected 1@6/0", obs_err, obs_err_k, obs_we);
        end
        run_window(32'h6000_0004, 32'h0, 3'b010, 0, 5'd8, 3, 3, 32'h0BAD_F00D);
        n_vec++;
        if (obs_err !== 0 || obs_we !== 1 || obs_we_k !== 9 || obs_we_data !== 32'h0BAD_F00D) begin
            n_miss++; $display("FAIL edge_handshake got err %0d we %0d@%0d data %h expected 0/1@9/0badf00d",
                               obs_err, obs_we, obs_we_k, obs_we_data);
        end
    endtask

    task automatic test_reset_mid;
        int we_cnt;
        @(negedge clk);
        req_mem_i = 1; mem_addr_i = 32'h0000_0040; mem_op_i = 3'b010; mem_store_i = 0; rd_waddr_i = 5'd7;
        @(negedge clk);
        req_mem_i = 0;
        #1;
        n_vec++;
        if (mem_req_o !== 1'b1) begin n_miss++; $display("FAIL rst_req_pre got %b expected 1", mem_req_o); end
        rst = 1;
        #1;
        n_vec++;
        if (mem_req_o !== 1'b0 || stall_o !== 1'b0) begin
            n_miss++; $display("FAIL rst_in_req got req %b stall %b expected 0/0", mem_req_o, stall_o);
        end
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        req_mem_i = 1; mem_addr_i = 32'h0000_0044;
        @(negedge clk);
        req_mem_i = 0; mem_gnt_i = 1;
        @(negedge clk);
        mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h1234_5678;
        #1;
        n_vec++;
        if (stall_o !== 1'b1) begin n_miss++; $display("FAIL rst_wait_pre got stall %b expected 1", stall_o); end
        rst = 1;
        #1;
        n_vec++;
        if (mem_req_o !== 1'b0 || stall_o !== 1'b0 || reg_we_o !== 1'b0) begin
            n_miss++; $display("FAIL rst_in_wait got req %b stall %b we %b expected 0/0/0", mem_req_o, stall_o, reg_we_o);
        end
        @(negedge clk);
        rst = 0;
        we_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_rvalid_i = (i == 0);
            #1;
            if (reg_we_o || stall_o) we_cnt++;
        end
        mem_rvalid_i = 0;
        n_vec++;
        if (we_cnt !== 0) begin n_miss++; $display("FAIL rst_late_rvalid got %0d active cycles expected 0", we_cnt); end
    endtask

    task automatic test_random;
        exp_t        e;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rdata;
        logic [2:0]  op;
        logic [4:0]  rd;
        bit          st;
        int          g;
        int          r;
        int          sel;
        for (int it = 0; it < 40; it++) begin
            sel = $urandom_range(0, 7);
            case (sel)
                0: begin op = 3'b000; st = 0; end
                1: begin op = 3'b001; st = 0; end
                2: begin op = 3'b010; st = 0; end
                3: begin op = 3'b100; st = 0; end
                4: begin op = 3'b101; st = 0; end
                5: begin op = 3'b000; st = 1; end
                6: begin op = 3'b001; st = 1; end
                default: begin op = 3'b010; st = 1; end
            endcase
            a = $urandom; wd = $urandom; rdata = $urandom; rd = 5'($urandom);
            g = $urandom_range(0, 5);
            r = $urandom_range(0, 5);
            e = model(a, wd, op, st, g, r, rdata);
            run_window(a, wd, op, st, rd, g, r, rdata);
            n_vec++;
            if (obs_mis !== int'(e.mis) || obs_stall !== e.n_stall || obs_req !== e.n_req || obs_err !== e.n_err) begin
                n_miss++; $display("FAIL rnd%0d_flow got mis %0d stall %0d req %0d err %0d expected %0d/%0d/%0d/%0d",
                                   it, obs_mis, obs_stall, obs_req, obs_err, e.mis, e.n_stall, e.n_req, e.n_err);
            end
            n_vec++;
            if (obs_we !== e.n_we) begin
                n_miss++; $display("FAIL rnd%0d_we got %0d expected %0d", it, obs_we, e.n_we);
            end
            if (e.n_we == 1) begin
                n_vec++;
                if (obs_we_data !== e.we_data || obs_we_addr !== rd || obs_we_k !== e.we_k) begin
                    n_miss++; $display("FAIL rnd%0d_wb got %h/%0d@%0d expected %h/%0d@%0d", it,
                                       obs_we_data, obs_we_addr, obs_we_k, e.we_data, rd, e.we_k);
                end
            end
            if (e.n_req > 0) begin
                n_vec++;
                if (obs_addr !== {a[31:2], 2'b00} || obs_sel !== e.sel || obs_wen !== st || obs_unstable) begin
                    n_miss++; $display("FAIL rnd%0d_bus got %h/%b/%b unstable %0d expected %h/%b/%b/0", it,
                                       obs_addr, obs_sel, obs_wen, obs_unstable, {a[31:2], 2'b00}, e.sel, st);
                end
                if (st) begin
                    n_vec++;
                    if (obs_wdata !== e.wdata) begin
                        n_miss++; $display("FAIL rnd%0d_wdata got %h expected %h", it, obs_wdata, e.wdata);
                    end
                end
            end
        end
    endtask

    initial begin
        rst = 1; req_mem_i = 0; mem_addr_i = 0; mem_wdata_i = 0; mem_op_i = 0; mem_store_i = 0;
        rd_waddr_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
        test_reset;
        test_lw;
        test_load_ext;
        test_store;
        test_misaligned;
        test_timeout;
        test_reset_mid;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/exu_mem_lsu.md
Name: exu_mem_lsu

Overview:
Load/store unit directly downstream of the EXU ALU datapath. It takes the effective address the datapath computes for memory ops (op1+op2), runs one bus transaction per instruction through a req/gnt/rvalid handshake, and performs byte-lane alignment and load sign/zero extension. It produces the GPR writeback and stalls the pipeline while a transaction is outstanding.

Parameters:
BUS_TIMEOUT, 255, cycles in REQ or WAIT before the transaction is aborted with mem_err_o; legal range 1..65535.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
req_mem_i  in  1  memory instruction valid this cycle (one-cycle pulse per instruction)
mem_addr_i  in  32  effective address from ALU datapath result
mem_wdata_i  in  32  store data (rs2)
mem_op_i  in  3  funct3: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu (loads); 000/001/010 sb/sh/sw (stores)
mem_store_i  in  1  1 = store, 0 = load
rd_waddr_i  in  5  load destination register
mem_req_o  out  1  bus request
mem_addr_o  out  32  word-aligned bus address ({addr[31:2],2'b00})
mem_we_o  out  1  bus write enable
mem_sel_o  out  4  byte strobes
mem_wdata_o  out  32  lane-replicated store data
mem_gnt_i  in  1  bus grant
mem_rvalid_i  in  1  read data valid
mem_rdata_i  in  32  read data
reg_we_o  out  1  GPR write pulse
reg_waddr_o  out  5  GPR write address
reg_wdata_o  out  32  aligned, extended load data
stall_o  out  1  hold upstream pipeline
misaligned_o  out  1  misaligned-access exception pulse
mem_err_o  out  1  bus timeout pulse

Behaviour:
- Reset: state IDLE. All registered outputs, the latched op, and the timeout counter are 0. Asynchronous reset mid-transaction drops mem_req_o immediately and suppresses any writeback.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - On req_mem_i, check alignment. Misaligned means lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]≠0.
  - Misaligned: misaligned_o=1 for exactly the next cycle, no bus activity, no reg write, stay IDLE.
  - Aligned: latch address, sel, wdata, op and rd, then go to REQ.
- REQ:
  - mem_req_o=1 and address/we/sel/wdata held stable until mem_gnt_i=1.
  - On gnt, a store returns to IDLE and a load goes to WAIT. mem_req_o deasserts the cycle after gnt.
- WAIT:
  - mem_rvalid_i is sampled only in WAIT. The slave must not assert rvalid in the gnt cycle.
  - On rvalid: reg_we_o=1 for one cycle (the next cycle), reg_waddr_o = latched rd, reg_wdata_o = extracted data. Return to IDLE.
- Lane rules:
  - sb: sel = 4'b0001<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - sh: sel = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{wdata[15:0]}}.
  - sw: sel = 4'b1111.
  - Loads drive sel=4'b1111 and we=0.
  - Load extract: byte = rdata[8*addr[1:0] +: 8]; half = rdata[16*addr[1] +: 16]. lb/lh sign-extend; lbu/lhu zero-extend.
- stall_o = (state≠IDLE) | (state==IDLE & req_mem_i & aligned). It is combinational, so upstream sees the stall in the acceptance cycle. It deasserts in the cycle the FSM returns to IDLE. A store therefore stalls for the acceptance cycle plus the REQ cycles; a load stalls until the writeback cycle.
- Timeout:
  - The 16-bit counter clears on entry to REQ and to WAIT and increments each cycle spent there.
  - When the counter reaches BUS_TIMEOUT without gnt (in REQ) or rvalid (in WAIT): mem_err_o pulses 1 cycle, mem_req_o drops, there is no reg write, and the FSM returns to IDLE.
  - If gnt or rvalid arrives in the same cycle the count is reached, the handshake wins and no error is raised.
- req_mem_i while state≠IDLE is ignored. Upstream guarantees this cannot occur because it is holding on stall_o.
- Only one transaction is ever outstanding.

Test Plan:
- lw addr 0x1000_0008, gnt on the first REQ cycle, rvalid 2 cycles later with rdata 0xDEADBEEF → mem_addr_o=0x1000_0008, sel=1111, we=0; reg_we_o pulses with wdata 0xDEADBEEF, waddr=rd; stall_o high from acceptance through the rvalid cycle.
- lb/lbu addr ...03, rdata 0x80FF_1234 → lb writes 0xFFFF_FF80 and lbu writes 0x0000_0080. lh addr ...02, rdata 0x8001_0000 → writes 0xFFFF_8001.
- sb addr ...01 with wdata 0x0000_00A5, gnt delayed 3 cycles → sel=0010, wdata_o=0xA5A5A5A5, req/addr stable for all 3 wait cycles, no reg_we_o.
- sw addr ...02 and lh addr ...01 → misaligned_o one-cycle pulse each, mem_req_o never asserted, stall_o never asserted.
- BUS_TIMEOUT=4 with gnt withheld → mem_err_o pulses when the count reaches 4, then IDLE and req=0. Repeat with gnt arriving in that same cycle → no error, normal completion.
- rst asserted in WAIT → mem_req_o, stall_o and reg_we_o are 0 immediately. A late rvalid after reset release produces no writeback.
